// File: rtl/mem_rr_arbiter_pkg.sv
// rtl/mem_rr_arbiter_pkg.sv - shared types and constants for the memory round-robin arbiter
package mem_rr_arbiter_pkg;

    // Core count shared with the SoC top; the arbiter defaults to it.
    localparam int N_CORES = 4;

    // Watchdog counter width; covers TIMEOUT_CYC up to 65535.
    localparam int WD_W = 16;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } arb_state_t;

    // Width of a port index; a single bit is kept even for two ports.
    function automatic int idw_of(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_rr_arbiter_rr_pick.sv
// rtl/mem_rr_arbiter_rr_pick.sv - combinational rotating-priority request picker
module rr_pick
    import mem_rr_arbiter_pkg::*;
#(
    parameter int N   = N_CORES,
    parameter int IDW = idw_of(N)
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [IDW-1:0] idx,
    output logic           any
);

    logic [IDW-1:0] cand;
    logic           found;

    // Walk ptr, ptr+1, ... (mod N) and report the first requester met.
    always_comb begin
        idx   = '0;
        any   = |req;
        cand  = ptr;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
            cand = (cand == IDW'(N - 1)) ? '0 : cand + 1'b1;
        end
    end

endmodule

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter sharing one memory target among native memory ports
module mem_rr_arbiter
    import mem_rr_arbiter_pkg::*;
#(
    parameter int          N_PORTS     = N_CORES,
    parameter int          TIMEOUT_CYC = 255,
    parameter logic [31:0] ERR_RDATA   = 32'h0000_0000,
    localparam int         IDW         = idw_of(N_PORTS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_PORTS-1:0]     m_valid,
    input  logic [32*N_PORTS-1:0]  m_addr,
    input  logic [32*N_PORTS-1:0]  m_wdata,
    input  logic [4*N_PORTS-1:0]   m_wstrb,
    output logic [N_PORTS-1:0]     m_ready,
    output logic [32*N_PORTS-1:0]  m_rdata,
    output logic                   s_valid,
    output logic [31:0]            s_addr,
    output logic [31:0]            s_wdata,
    output logic [3:0]             s_wstrb,
    input  logic                   s_ready,
    input  logic [31:0]            s_rdata,
    output logic [IDW-1:0]         grant_id,
    output logic                   bus_err
);

    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [IDW-1:0]  LAST_ID = IDW'(N_PORTS - 1);

    arb_state_t      state;
    arb_state_t      state_next;
    logic [IDW-1:0]  ptr;
    logic [IDW-1:0]  pick_idx;
    logic            pick_any;
    logic [WD_W-1:0] wd;
    logic            load_req;
    logic            done_ok;
    logic            done_err;
    logic [31:0]     sel_addr;
    logic [31:0]     sel_wdata;
    logic [3:0]      sel_wstrb;

    rr_pick #(
        .N   (N_PORTS),
        .IDW (IDW)
    ) u_pick (
        .req (m_valid),
        .ptr (ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Route the picked core's request fields towards the target latch.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_wstrb = '0;
        for (int i = 0; i < N_PORTS; i++) begin
            if (pick_idx == IDW'(i)) begin
                sel_addr  = m_addr[32*i +: 32];
                sel_wdata = m_wdata[32*i +: 32];
                sel_wstrb = m_wstrb[4*i +: 4];
            end
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus one-cycle strobes: accept, normal completion, watchdog completion.
    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pick_any) begin
                    load_req   = 1'b1;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (s_ready) begin
                    done_ok    = 1'b1;
                    state_next = ST_DONE;
                end else if (wd == WD_LAST) begin
                    done_err   = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Capture the winner's request; fields stay frozen until the next accept.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_addr   <= '0;
            s_wdata  <= '0;
            s_wstrb  <= '0;
            grant_id <= '0;
        end else if (load_req) begin
            s_addr   <= sel_addr;
            s_wdata  <= sel_wdata;
            s_wstrb  <= sel_wstrb;
            grant_id <= pick_idx;
        end
    end

    // Target request is raised on accept and dropped on either kind of completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_valid <= 1'b0;
        end else if (load_req) begin
            s_valid <= 1'b1;
        end else if (done_ok || done_err) begin
            s_valid <= 1'b0;
        end
    end

    // Watchdog: cleared on accept, advances only while waiting on the target.
    always_ff @(posedge clk) begin
        if (reset) begin
            wd <= '0;
        end else if (load_req) begin
            wd <= '0;
        end else if (state == ST_BUSY && !done_ok && !done_err) begin
            wd <= wd + 1'b1;
        end
    end

    // Completion pulse and read data go to the granted core only.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_ready <= '0;
            m_rdata <= '0;
            bus_err <= 1'b0;
        end else begin
            m_ready <= '0;
            bus_err <= 1'b0;
            if (done_ok || done_err) begin
                bus_err <= done_err;
                for (int i = 0; i < N_PORTS; i++) begin
                    if (grant_id == IDW'(i)) begin
                        m_ready[i]         <= 1'b1;
                        m_rdata[32*i +: 32] <= done_ok ? s_rdata : ERR_RDATA;
                    end
                end
            end
        end
    end

    // After each transaction the winner drops to lowest priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (state == ST_DONE) begin
            ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
        end
    end

endmodule
